// File: rtl/output_axi_reader.sv
// AXI4-Lite read-only slave that drains the output memory, one word per beat.
// Define OUTPUT_AXI_READER_ERR_EN to answer misaligned/out-of-range reads with SLVERR.
module output_axi_reader #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 12,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [2*DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic                      mem_en,
    output logic [ADDR_WIDTH-2:0]     mem_addr,
    input  logic [2*DATA_WIDTH-1:0]   mem_dout,
    input  logic                      count_clr,
    output logic [ADDR_WIDTH-1:0]     rd_count
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, MEM, CAP, RESP} state_t;

    state_t                    state_q, state_d;
    logic [ADDR_WIDTH-2:0]     waddr_q, waddr_d;
    logic [2*DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;
    logic [ADDR_WIDTH-1:0]     cnt_q, cnt_d;
    logic                      bad_addr;
    logic                      beat_ok;

`ifdef OUTPUT_AXI_READER_ERR_EN
    assign bad_addr = (|s_axi_araddr[1:0]) |
                      (|s_axi_araddr[AXI_ADDR_WIDTH-1:ADDR_WIDTH+1]);
`else
    // Byte lane and upper bits are don't-care: the address wraps over the memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_araddr[AXI_ADDR_WIDTH-1:ADDR_WIDTH+1],
                                s_axi_araddr[1:0]};
    assign bad_addr = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        unique case (state_q)
            IDLE: begin
                if (s_axi_arvalid) begin
                    waddr_d = s_axi_araddr[ADDR_WIDTH:2];
                    if (bad_addr) begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                        state_d = RESP;
                    end else begin
                        state_d = MEM;
                    end
                end
            end
            MEM: state_d = CAP;
            CAP: begin
                rdata_d = mem_dout;
                rresp_d = RESP_OKAY;
                state_d = RESP;
            end
            RESP: begin
                if (s_axi_rready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear wins over a same-cycle beat; the count sticks at all-ones.
    assign beat_ok = (state_q == RESP) && s_axi_rready && (rresp_q == RESP_OKAY);

    always_comb begin
        cnt_d = cnt_q;
        if (count_clr) begin
            cnt_d = '0;
        end else if (beat_ok && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            waddr_q <= '0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s_axi_arready = (state_q == IDLE) && !rst;
    assign s_axi_rvalid  = (state_q == RESP) && !rst;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign mem_en        = (state_q == MEM);
    assign mem_addr      = waddr_q;
    assign rd_count      = cnt_q;

endmodule

// File: tb/tb_output_axi_reader.sv
// Directed bench for output_axi_reader with a registered-read memory model.
// Expected words come from an element-level formula, independent of the DUT.
module tb_output_axi_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic        mem_en;
    logic [10:0] mem_addr;
    logic [31:0] mem_q;
    logic        count_clr;
    logic [11:0] rd_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulses = 0;
    logic [10:0] pulse_addr;
    logic [31:0] mem [0:2047];

    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    int          rd_lat;
    int          rd_pulses;
    int          rd_t;
    bit          rd_stable;
    logic        rd_arready_after;

    output_axi_reader dut (
        .clk(clk), .rst(rst),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_dout(mem_q), .count_clr(count_clr), .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) begin
            mem_q      <= mem[mem_addr];
            pulses     <= pulses + 1;
            pulse_addr <= mem_addr;
        end
    end

    function automatic logic [15:0] elem(input int e);
        if (e == 10) return 16'h1234;
        if (e == 11) return 16'hABCD;
        return 16'(e) ^ 16'hA500;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        int w;
        w = int'(a[12:2]);
        return {elem(2 * w), elem(2 * w + 1)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [31:0] a, input int stall, input bit clr);
        int n;
        int p0;
        p0 = pulses;
        rd_pulses = -1;
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        s_axi_rready  = (stall == 0);
        n = 0;
        while (!s_axi_arready && n < 20) begin
            tick();
            n++;
        end
        if (!s_axi_arready) begin
            total++; bad++;
            $display("FAIL ar_timeout addr=%h got arready=0 want 1", a);
            s_axi_arvalid = 1'b0;
            return;
        end
        tick();
        s_axi_arvalid = 1'b0;
        rd_lat = 1;
        while (!s_axi_rvalid && rd_lat < 20) begin
            tick();
            rd_lat++;
        end
        if (!s_axi_rvalid) begin
            total++; bad++;
            $display("FAIL r_timeout addr=%h got rvalid=0 want 1", a);
            return;
        end
        rd_t      = cyc;
        rd_data   = s_axi_rdata;
        rd_resp   = s_axi_rresp;
        rd_stable = 1'b1;
        for (int i = 0; i < stall; i++) begin
            s_axi_arvalid = 1'b1;
            s_axi_araddr  = a ^ 32'h10;
            tick();
            if (s_axi_rdata !== rd_data || s_axi_rresp !== rd_resp ||
                s_axi_rvalid !== 1'b1 || s_axi_arready !== 1'b0)
                rd_stable = 1'b0;
        end
        s_axi_arvalid = 1'b0;
        s_axi_araddr  = a;
        s_axi_rready  = 1'b1;
        count_clr     = clr;
        tick();
        count_clr = 1'b0;
        rd_arready_after = s_axi_arready;
        rd_pulses = pulses - p0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (s_axi_arready !== 1'b0) begin bad++; $display("FAIL rst_arready got %b want 0", s_axi_arready); end
        rst = 1'b0;
        #1;
        total++; if (s_axi_arready !== 1'b1) begin bad++; $display("FAIL post_rst_arready got %b want 1", s_axi_arready); end
        total++; if (s_axi_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got %b want 0", s_axi_rvalid); end
        total++; if (s_axi_rdata !== 32'h0 || s_axi_rresp !== 2'b00) begin bad++; $display("FAIL rst_rdata got %h/%b want 0/00", s_axi_rdata, s_axi_rresp); end
        total++; if (mem_en !== 1'b0 || mem_addr !== 11'h0) begin bad++; $display("FAIL rst_mem got en=%b addr=%h want 0/0", mem_en, mem_addr); end
        total++; if (rd_count !== 12'h0) begin bad++; $display("FAIL rst_count got %0d want 0", rd_count); end
    endtask

    task automatic test_single();
        do_read(32'h14, 0, 1'b0);
        total++; if (rd_pulses !== 1 || pulse_addr !== 11'd5) begin bad++; $display("FAIL single_mem got pulses=%0d addr=%0d want 1/5", rd_pulses, pulse_addr); end
        total++; if (rd_lat !== 3) begin bad++; $display("FAIL single_lat got %0d want 3", rd_lat); end
        total++; if (rd_data !== 32'h1234ABCD || rd_resp !== 2'b00) begin bad++; $display("FAIL single_data got %h/%b want 1234abcd/00", rd_data, rd_resp); end
        total++; if (rd_count !== 12'd1) begin bad++; $display("FAIL single_count got %0d want 1", rd_count); end
        total++; if (rd_arready_after !== 1'b1) begin bad++; $display("FAIL single_arready got %b want 1", rd_arready_after); end
    endtask

    task automatic test_backpressure();
        do_read(32'h40, 7, 1'b0);
        total++; if (rd_stable !== 1'b1) begin bad++; $display("FAIL bp_stable got %b want 1", rd_stable); end
        total++; if (rd_data !== exp_word(32'h40)) begin bad++; $display("FAIL bp_data got %h want %h", rd_data, exp_word(32'h40)); end
        total++; if (rd_pulses !== 1) begin bad++; $display("FAIL bp_busy_ar got pulses=%0d want 1", rd_pulses); end
        total++; if (rd_arready_after !== 1'b1) begin bad++; $display("FAIL bp_arready got %b want 1", rd_arready_after); end
        total++; if (rd_count !== 12'd2) begin bad++; $display("FAIL bp_count got %0d want 2", rd_count); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4];
        int prev_t;
        addrs = '{32'h0, 32'h4, 32'h8, 32'h1FFC};
        prev_t = 0;
        for (int i = 0; i < 4; i++) begin
            do_read(addrs[i], 0, 1'b0);
            total++; if (rd_data !== exp_word(addrs[i])) begin bad++; $display("FAIL b2b_data%0d got %h want %h", i, rd_data, exp_word(addrs[i])); end
            if (i > 0) begin
                total++; if (rd_t - prev_t !== 4) begin bad++; $display("FAIL b2b_gap%0d got %0d want 4", i, rd_t - prev_t); end
            end
            prev_t = rd_t;
        end
        total++; if (rd_data !== {elem(4094), elem(4095)}) begin bad++; $display("FAIL b2b_last got %h want %h", rd_data, {elem(4094), elem(4095)}); end
        total++; if (rd_count !== 12'd6) begin bad++; $display("FAIL b2b_count got %0d want 6", rd_count); end
    endtask

    task automatic test_addr_map();
`ifdef OUTPUT_AXI_READER_ERR_EN
        logic [31:0] eaddr [2];
        eaddr = '{32'h2002, 32'h6};
        for (int i = 0; i < 2; i++) begin
            do_read(eaddr[i], 0, 1'b0);
            total++; if (rd_resp !== 2'b10 || rd_data !== 32'h0) begin bad++; $display("FAIL err_resp%0d got %b/%h want 10/0", i, rd_resp, rd_data); end
            total++; if (rd_pulses !== 0 || rd_lat !== 1) begin bad++; $display("FAIL err_path%0d got pulses=%0d lat=%0d want 0/1", i, rd_pulses, rd_lat); end
            total++; if (rd_count !== 12'd6) begin bad++; $display("FAIL err_count%0d got %0d want 6", i, rd_count); end
        end
`else
        do_read(32'h2004, 0, 1'b0);
        total++; if (rd_resp !== 2'b00 || rd_data !== exp_word(32'h4)) begin bad++; $display("FAIL wrap_data got %b/%h want 00/%h", rd_resp, rd_data, exp_word(32'h4)); end
        total++; if (pulse_addr !== 11'd1 || rd_pulses !== 1) begin bad++; $display("FAIL wrap_mem got addr=%0d pulses=%0d want 1/1", pulse_addr, rd_pulses); end
        do_read(32'h16, 0, 1'b0);
        total++; if (rd_resp !== 2'b00 || rd_data !== 32'h1234ABCD) begin bad++; $display("FAIL lowbits_data got %b/%h want 00/1234abcd", rd_resp, rd_data); end
        total++; if (rd_count !== 12'd8) begin bad++; $display("FAIL wrap_count got %0d want 8", rd_count); end
`endif
    endtask

    task automatic test_reset_mid(input int depth);
        bit seen;
        s_axi_araddr  = 32'h14;
        s_axi_arvalid = 1'b1;
        s_axi_rready  = 1'b0;
        tick();
        s_axi_arvalid = 1'b0;
        for (int i = 0; i < depth; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s_axi_rready = 1'b1;
        #1;
        total++; if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin bad++; $display("FAIL rmid%0d_ctl got rvalid=%b arready=%b want 0/1", depth, s_axi_rvalid, s_axi_arready); end
        total++; if (rd_count !== 12'd0 || s_axi_rdata !== 32'h0) begin bad++; $display("FAIL rmid%0d_regs got count=%0d rdata=%h want 0/0", depth, rd_count, s_axi_rdata); end
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (s_axi_rvalid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rmid%0d_beat got stray rvalid want none", depth); end
        do_read(32'h14, 0, 1'b0);
        total++; if (rd_data !== 32'h1234ABCD || rd_count !== 12'd1) begin bad++; $display("FAIL rmid%0d_fresh got %h cnt=%0d want 1234abcd/1", depth, rd_data, rd_count); end
    endtask

    task automatic test_count();
        do_read(32'h8, 0, 1'b1);
        total++; if (rd_count !== 12'd0) begin bad++; $display("FAIL clr_hs got %0d want 0", rd_count); end
        for (int i = 0; i < 4095; i++) begin
            do_read(32'((i % 2048) * 4), 0, 1'b0);
        end
        total++; if (rd_count !== 12'd4095) begin bad++; $display("FAIL sat_reach got %0d want 4095", rd_count); end
        do_read(32'h14, 0, 1'b0);
        total++; if (rd_count !== 12'd4095) begin bad++; $display("FAIL sat_hold got %0d want 4095", rd_count); end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = {elem(2 * i), elem(2 * i + 1)};
        mem_q         = 32'h0;
        pulse_addr    = '0;
        rst           = 1'b1;
        s_axi_araddr  = 32'h0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        count_clr     = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_addr_map();
        test_reset_mid(1);
        test_reset_mid(2);
        test_count();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
